uart_tx_sequencer: RTL and testbench
====================================

Name: uart_tx_sequencer

Overview:
- Transmit-side controller for the UART.
- Takes the control-register fields (word length, stop bits, oversample mode, enable) and a data word from the TX FIFO over a valid/ready handshake.
- Generates the bit timing from an oversample counter and sequences the start, data, optional parity and stop bits onto the serial line.
- Sits between the register file / TX FIFO and the txd pad.

Parameters:
- DATA_W, 8: width of tx_data; maximum word length in bits.
- CLKS_PER_SAMPLE, 16: clk cycles per oversample tick; must be at least 1.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- enable_uart  input  1  UART enable from CNTRL0[7]
- word_length  input  5  data bits per frame, from CNTRL0[4:0]
- num_stop_bits  input  1  0 = one stop bit, 1 = two stop bits
- oversample_by_3  input  1  1 = 3 samples per bit, 0 = 16 samples per bit
- tx_data  input  DATA_W  word to send, LSB first
- tx_valid  input  1  TX FIFO has a word
- tx_ready  output  1  sequencer accepts a word this cycle
- txd  output  1  serial output; idle level 1
- busy  output  1  frame in progress
- tx_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset and clock: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: state IDLE, txd=1, busy=0, tx_done=0, all counters 0. Reset asserted mid-frame returns txd to 1 immediately; the frame is abandoned.
- Bit period: BP = CLKS_PER_SAMPLE × SPB clk cycles, where SPB = 3 if oversample_by_3 else 16.
  - Sample counter runs 0..CLKS_PER_SAMPLE-1; tick counter runs 0..SPB-1.
  - Every bit, including start, parity and stop, is held exactly BP cycles.
- Effective word length: WL = word_length, clamped.
  - Values 0..4 are treated as 5.
  - Values greater than DATA_W are treated as DATA_W.
- tx_ready = (state==IDLE) & enable_uart; purely combinational, with no dependency on tx_valid.
- Accept occurs on tx_valid & tx_ready.
  - Latches tx_data, WL, num_stop_bits and oversample_by_3 into shadow registers.
  - Register changes during a frame have no effect on that frame.
- States:
  - IDLE: txd=1, busy=0. On accept, go to START next cycle.
  - START: txd=0 for BP cycles, then go to DATA with bit index 0.
  - DATA: txd = shadow[bit index] for BP cycles. The index increments per bit; after bit WL-1, go to PARITY if compiled in, else STOP.
  - PARITY: see Optional Feature.
  - STOP: txd=1 for BP cycles, or 2×BP if two stop bits are latched. Then go to IDLE.
- busy=1 in every state except IDLE.
- tx_done=1 for exactly the first IDLE cycle after STOP, i.e. the same cycle tx_ready can reassert.
- Back-to-back frames:
  - An accept in the tx_done cycle starts the next START on the following cycle.
  - This leaves exactly one cycle of txd=1 beyond the stop bits between frames.
- enable_uart dropped mid-frame: the current frame completes normally; no new accept occurs until enable_uart=1.
- tx_valid dropping without an accept has no effect; tx_data is sampled only on accept.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - Adds input ports parity_en (1 bit) and parity_odd (1 bit); both are latched on accept.
  - If parity_en is latched as 1, a PARITY state is inserted between DATA and STOP, lasting BP cycles.
  - Parity value = XOR of the WL transmitted bits (even parity), inverted when parity_odd=1.
  - If parity_en is latched as 0, DATA goes straight to STOP.
- Undefined: no parity ports and no PARITY state; frames are start + WL data bits + stop.

Test Plan:
- Basic frame. Config: CLKS_PER_SAMPLE=1, oversample_by_3=1 (BP=3), word_length=8, one stop bit. Stimulus: send 8'hA5. Required response:
  - txd holds each level for 3 cycles: 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop).
  - busy is high for 30 cycles.
  - tx_done pulses once, on the cycle after the stop bit ends.
- Two stop bits, clamped word length. Config: BP=3, word_length=3 (clamped to 5), num_stop_bits=1. Stimulus: send 8'h1F. Required response: txd is 0, then five 1 bits, then stop high for 6 cycles; busy is high for 24 cycles.
- Oversample by 16 and FIFO back-to-back. Config: CLKS_PER_SAMPLE=2, oversample_by_3=0 (BP=32), tx_valid held high with words 8'h00 and 8'hFF.
  - Each frame is 320 cycles.
  - The second accept occurs in the tx_done cycle.
  - Exactly one idle cycle (txd=1) separates the frames.
- Mid-frame changes: change word_length to 5 and drop enable_uart during the DATA state of a 8'h3C frame. Required response:
  - All 8 data bits are still sent.
  - tx_ready stays 0 after the frame until enable_uart returns to 1.
- Reset mid-frame: assert reset_n=0 during the DATA state. Required response:
  - txd goes to 1 and busy to 0 asynchronously.
  - After release, the next accepted frame is bit-exact.
- Parity (UART_PARITY_EN defined), BP=3, word_length=8. Stimulus and required response:
  - 8'hA5 with parity_odd=0: the parity bit is 0.
  - The same word with parity_odd=1: the parity bit is 1.
  - Each frame is 33 cycles.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: start, data (LSB first), optional parity and stop bits on txd.
// Define UART_PARITY_EN to add the parity_en/parity_odd ports and the PARITY bit.
module uart_tx_sequencer #(
  parameter int DATA_W          = 8,
  parameter int CLKS_PER_SAMPLE = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable_uart,
  input  logic [4:0]        word_length,
  input  logic              num_stop_bits,
  input  logic              oversample_by_3,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
`ifdef UART_PARITY_EN
  input  logic              parity_en,
  input  logic              parity_odd,
`endif
  output logic              tx_ready,
  output logic              txd,
  output logic              busy,
  output logic              tx_done
);

  localparam int CNT_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [4:0] WL_MAX = 5'(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    sample_cnt_reg;
  logic [3:0]          tick_cnt_reg;
  logic [4:0]          bit_idx_reg;
  logic [4:0]          wl_reg;
  logic [DATA_W-1:0]   data_sh_reg;
  logic                two_stop_reg;
  logic                os3_reg;
  logic                stop_second_reg;
  logic                txd_reg;
  logic                busy_reg;
  logic                tx_done_reg;

  logic [4:0]          wl_clamped;
  logic [3:0]          tick_last;
  logic                bit_end;
  logic                accept;

  assign tx_ready  = (state_reg == IDLE) && enable_uart;
  assign accept    = tx_ready && tx_valid;
  assign tick_last = os3_reg ? 4'd2 : 4'd15;
  assign bit_end   = (sample_cnt_reg == SAMPLE_LAST) && (tick_cnt_reg == tick_last);
  assign txd       = txd_reg;
  assign busy      = busy_reg;
  assign tx_done   = tx_done_reg;

  always_comb begin
    wl_clamped = word_length;
    if (word_length < 5'd5)
      wl_clamped = 5'd5;
    else if (word_length > WL_MAX)
      wl_clamped = WL_MAX;
  end

`ifdef UART_PARITY_EN
  logic par_en_reg;
  logic par_bit_reg;
  logic par_calc;

  // Parity covers only the WL bits that will actually be sent.
  always_comb begin
    par_calc = parity_odd;
    for (int i = 0; i < DATA_W; i++)
      if (i < int'(wl_clamped))
        par_calc = par_calc ^ tx_data[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
    end else if (accept) begin
      par_en_reg  <= parity_en;
      par_bit_reg <= par_calc;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      sample_cnt_reg  <= '0;
      tick_cnt_reg    <= '0;
      bit_idx_reg     <= '0;
      wl_reg          <= '0;
      data_sh_reg     <= '0;
      two_stop_reg    <= 1'b0;
      os3_reg         <= 1'b0;
      stop_second_reg <= 1'b0;
      txd_reg         <= 1'b1;
      busy_reg        <= 1'b0;
      tx_done_reg     <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          txd_reg  <= 1'b1;
          busy_reg <= 1'b0;
          if (accept) begin
            state_reg       <= START;
            txd_reg         <= 1'b0;
            busy_reg        <= 1'b1;
            data_sh_reg     <= tx_data;
            wl_reg          <= wl_clamped;
            two_stop_reg    <= num_stop_bits;
            os3_reg         <= oversample_by_3;
            sample_cnt_reg  <= '0;
            tick_cnt_reg    <= '0;
            bit_idx_reg     <= '0;
            stop_second_reg <= 1'b0;
          end
        end
        default: begin
          if (!bit_end) begin
            if (sample_cnt_reg == SAMPLE_LAST) begin
              sample_cnt_reg <= '0;
              tick_cnt_reg   <= tick_cnt_reg + 4'd1;
            end else begin
              sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
            end
          end else begin
            sample_cnt_reg <= '0;
            tick_cnt_reg   <= '0;
            case (state_reg)
              START: begin
                state_reg   <= DATA;
                bit_idx_reg <= '0;
                txd_reg     <= data_sh_reg[0];
                data_sh_reg <= data_sh_reg >> 1;
              end
              DATA: begin
                if (bit_idx_reg == wl_reg - 5'd1) begin
`ifdef UART_PARITY_EN
                  if (par_en_reg) begin
                    state_reg <= PARITY;
                    txd_reg   <= par_bit_reg;
                  end else begin
                    state_reg <= STOP;
                    txd_reg   <= 1'b1;
                  end
`else
                  state_reg <= STOP;
                  txd_reg   <= 1'b1;
`endif
                end else begin
                  bit_idx_reg <= bit_idx_reg + 5'd1;
                  txd_reg     <= data_sh_reg[0];
                  data_sh_reg <= data_sh_reg >> 1;
                end
              end
              PARITY: begin
                state_reg <= STOP;
                txd_reg   <= 1'b1;
              end
              STOP: begin
                // A second stop bit simply re-runs the bit timer once more.
                if (two_stop_reg && !stop_second_reg) begin
                  stop_second_reg <= 1'b1;
                end else begin
                  state_reg   <= IDLE;
                  busy_reg    <= 1'b0;
                  tx_done_reg <= 1'b1;
                end
              end
              default: begin
                state_reg <= IDLE;
                txd_reg   <= 1'b1;
                busy_reg  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: captures whole frames on txd and compares them to hand-built bit streams.
module tb_uart_tx_sequencer;

  logic       clk;
  logic       reset_n;
  logic       enable_uart;
  logic [4:0] word_length;
  logic       num_stop_bits;
  logic       oversample_by_3;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, txd, busy, tx_done;
  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2, txd2, busy2, tx_done2;
  logic       parity_en, parity_odd;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_sequencer #(.DATA_W(8), .CLKS_PER_SAMPLE(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable_uart(enable_uart), .word_length(word_length),
    .num_stop_bits(num_stop_bits), .oversample_by_3(oversample_by_3),
    .tx_data(tx_data), .tx_valid(tx_valid),
`ifdef UART_PARITY_EN
    .parity_en(parity_en), .parity_odd(parity_odd),
`endif
    .tx_ready(tx_ready), .txd(txd), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_sequencer #(.DATA_W(8), .CLKS_PER_SAMPLE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable_uart(enable_uart), .word_length(word_length),
    .num_stop_bits(num_stop_bits), .oversample_by_3(oversample_by_3),
    .tx_data(tx_data2), .tx_valid(tx_valid2),
`ifdef UART_PARITY_EN
    .parity_en(parity_en), .parity_odd(parity_odd),
`endif
    .tx_ready(tx_ready2), .txd(txd2), .busy(busy2), .tx_done(tx_done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input logic [1023:0] obs, input int nobs,
                         input logic [1023:0] exp, input int nexp);
    int first;
    checks++;
    assert (obs === exp && nobs == nexp) else begin
      failures++;
      first = -1;
      for (int i = 1023; i >= 0; i--) if (obs[i] !== exp[i]) first = i;
      $error("FAIL %s observed_len=%0d expected_len=%0d first_diff_cycle=%0d", tag, nobs, nexp, first);
    end
  endtask

  // Expected txd per clk cycle: start, WL data bits LSB first, optional parity, stop bits.
  task automatic build_exp(input logic [7:0] d, input int wl, input int bp, input int stops,
                           input int par, output logic [1023:0] seq, output int len);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < wl; i++) bits.push_back(d[i]);
    if (par >= 0) bits.push_back(par[0]);
    for (int i = 0; i < stops; i++) bits.push_back(1'b1);
    seq = '0;
    len = 0;
    foreach (bits[k])
      for (int j = 0; j < bp; j++) begin
        seq[len] = bits[k];
        len++;
      end
  endtask

  // Called on the negedge of the first START cycle; returns on the first idle negedge.
  task automatic capture(input int which, output int n, output logic [1023:0] seq);
    n = 0;
    seq = '0;
    while (((which == 0) ? busy : busy2) === 1'b1 && n < 1000) begin
      seq[n] = (which == 0) ? txd : txd2;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic start_frame(input logic [7:0] d);
    chk("ready_before_accept", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~d;
    chk("busy_after_accept", busy, 1);
  endtask

  logic [1023:0] seq, exp_seq;
  int n, exp_n;

  initial begin
    reset_n = 1'b0; enable_uart = 1'b0; word_length = 5'd8; num_stop_bits = 1'b0;
    oversample_by_3 = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
    tx_data2 = 8'h00; tx_valid2 = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", tx_done, 0);
    chk("reset_ready_disabled", tx_ready, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_disabled_idle", tx_ready, 0);
    enable_uart = 1'b1;
    #1 chk("ready_enabled", tx_ready, 1);
    @(negedge clk);

    // Basic 8N1 frame, BP=3.
    start_frame(8'hA5);
    capture(0, n, seq);
    build_exp(8'hA5, 8, 3, 1, -1, exp_seq, exp_n);
    chk_seq("frame_a5", seq, n, exp_seq, exp_n);
    chk("busy_len_a5", n, 30);
    chk("done_pulse_a5", tx_done, 1);
    chk("idle_txd_a5", txd, 1);
    @(negedge clk);
    chk("done_single_a5", tx_done, 0);

    // Word length 3 clamps to 5, two stop bits.
    word_length = 5'd3; num_stop_bits = 1'b1;
    start_frame(8'h1F);
    capture(0, n, seq);
    build_exp(8'h1F, 5, 3, 2, -1, exp_seq, exp_n);
    chk_seq("frame_1f_wl5_2stop", seq, n, exp_seq, exp_n);
    chk("busy_len_1f", n, 24);
    chk("done_pulse_1f", tx_done, 1);
    @(negedge clk);
    word_length = 5'd8; num_stop_bits = 1'b0;

    // Oversample by 16, CLKS_PER_SAMPLE=2, FIFO held valid back to back.
    oversample_by_3 = 1'b0;
    tx_valid2 = 1'b1; tx_data2 = 8'h00;
    @(negedge clk);
    tx_data2 = 8'hFF;
    chk("b2b_busy_first", busy2, 1);
    capture(1, n, seq);
    build_exp(8'h00, 8, 32, 1, -1, exp_seq, exp_n);
    chk_seq("b2b_frame_00", seq, n, exp_seq, exp_n);
    chk("b2b_len_00", n, 320);
    chk("b2b_done", tx_done2, 1);
    chk("b2b_ready_in_done", tx_ready2, 1);
    chk("b2b_gap_txd", txd2, 1);
    @(negedge clk);
    tx_valid2 = 1'b0;
    chk("b2b_second_started", busy2, 1);
    chk("b2b_done_cleared", tx_done2, 0);
    capture(1, n, seq);
    build_exp(8'hFF, 8, 32, 1, -1, exp_seq, exp_n);
    chk_seq("b2b_frame_ff", seq, n, exp_seq, exp_n);
    chk("b2b_len_ff", n, 320);
    chk("b2b_done2", tx_done2, 1);
    @(negedge clk);
    oversample_by_3 = 1'b1;

    // Register changes and enable drop mid-frame leave the frame untouched.
    start_frame(8'h3C);
    fork
      capture(0, n, seq);
      begin
        repeat (6) @(negedge clk);
        word_length = 5'd5;
        enable_uart = 1'b0;
      end
    join
    build_exp(8'h3C, 8, 3, 1, -1, exp_seq, exp_n);
    chk_seq("frame_3c_midchange", seq, n, exp_seq, exp_n);
    chk("done_3c", tx_done, 1);
    chk("ready_off_after_3c", tx_ready, 0);
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_accept_disabled", busy, 0);
    chk("ready_still_off", tx_ready, 0);
    tx_valid = 1'b0; word_length = 5'd8; enable_uart = 1'b1;
    #1 chk("ready_back_on", tx_ready, 1);
    @(negedge clk);

    // Asynchronous reset during DATA, then a clean frame.
    start_frame(8'hA5);
    repeat (7) @(negedge clk);
    chk("pre_reset_data_bit1", txd, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_txd", txd, 1);
    chk("async_reset_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_frame(8'h5A);
    capture(0, n, seq);
    build_exp(8'h5A, 8, 3, 1, -1, exp_seq, exp_n);
    chk_seq("frame_5a_after_reset", seq, n, exp_seq, exp_n);
    chk("done_5a", tx_done, 1);
    @(negedge clk);

`ifdef UART_PARITY_EN
    parity_en = 1'b1; parity_odd = 1'b0;
    start_frame(8'hA5);
    capture(0, n, seq);
    build_exp(8'hA5, 8, 3, 1, 0, exp_seq, exp_n);
    chk_seq("parity_even_a5", seq, n, exp_seq, exp_n);
    chk("parity_even_len", n, 33);
    @(negedge clk);
    parity_odd = 1'b1;
    start_frame(8'hA5);
    capture(0, n, seq);
    build_exp(8'hA5, 8, 3, 1, 1, exp_seq, exp_n);
    chk_seq("parity_odd_a5", seq, n, exp_seq, exp_n);
    chk("parity_odd_len", n, 33);
    @(negedge clk);
    parity_en = 1'b0; parity_odd = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
